mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, words of storage (power of two, 16..1024).
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response (0..7).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; clock clk.
REQ-005 req  input  1  controller request; held high with addr/we/wdata/wstrb stable until ready.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  write data.
REQ-009 wstrb  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-010 rdata  output  32  read data; valid only in the ready cycle.
REQ-011 ready  output  1  one-cycle response pulse; ends the transaction.
REQ-012 err  output  1  error flag; valid only in the ready cycle.
REQ-013 busy  output  1  high while a transaction is accepted and unanswered (WAIT or RESP).

Function
REQ-014 FSM states: IDLE, WAIT, RESP; encoding free.
REQ-015 IDLE: req=1 -> capture addr, we, wdata, wstrb into internal registers; go WAIT when LATENCY>0, else RESP.
REQ-016 IDLE: req=0 -> stay IDLE; no storage access.
REQ-017 WAIT: down-counter loaded with LATENCY-1 on accept; decrement each cycle; counter=0 -> RESP.
REQ-018 Request accept to ready latency: exactly LATENCY+1 cycles (ready high in cycle N+LATENCY+1 when req first seen high in IDLE at cycle N).
REQ-019 RESP: ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-020 req high in the RESP cycle is not a new request; req high in IDLE cycle after RESP starts a new transaction.
REQ-021 Captured registers used for the whole transaction; input changes after accept ignored.
REQ-022 Word index = captured addr[log2(DEPTH_WORDS)+1:2].
REQ-023 err=1 in RESP when captured addr[1:0]!=0 or captured addr >= 4*DEPTH_WORDS.
REQ-024 Read, no error: rdata = stored word at index in RESP cycle, err=0.
REQ-025 Write, no error: lanes with wstrb bit set updated at the RESP clock edge; other lanes unchanged; rdata=0.
REQ-026 Write with wstrb=0: no storage change, ready still asserted, err=0.
REQ-027 Any error: no storage change, rdata=0, err=1.
REQ-028 rdata, err forced 0 outside the RESP cycle.
REQ-029 busy=1 in WAIT and RESP; 0 in IDLE.
REQ-030 Storage written only by REQ-025; no other side effects.

Reset
REQ-031 rst low: state=IDLE, counter=0, ready=0, err=0, busy=0, rdata=0 immediately (asynchronous).
REQ-032 Reset mid-transaction aborts it: no ready pulse, pending write not committed.
REQ-033 Storage contents not cleared by reset; unwritten words read as undefined.
REQ-034 First request accepted in the first IDLE cycle after rst rises with req=1.

Verification
REQ-035 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 -> ready in cycle 3 after accept of each, rdata=0xDEADBEEF, err=0.
REQ-036 Partial write: after REQ-035, write 0x10 wdata=0x00000055 wstrb=4'b0001; read 0x10 -> rdata=0xDEADBE55.
REQ-037 Error: read addr=0x12 -> err=1, rdata=0; write addr=0x100 (DEPTH_WORDS=64) wdata=0x1 -> err=1, subsequent read 0x0 unchanged.
REQ-038 LATENCY=0: read accepted cycle N -> ready cycle N+1; req held high through ready -> second transaction accepted cycle N+2, ready N+3, ready never high two consecutive cycles.
REQ-039 Reset abort: write 0x20 wdata=0x12345678 accepted, rst low during WAIT -> ready stays 0, busy=0; after reset, read 0x20 returns pre-test contents, not 0x12345678.
REQ-040 Input stability: change addr/wdata after accept during WAIT -> response reflects captured values only.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between a memory controller (master) and mem_responder (slave).
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one request, waits LATENCY cycles,
// then answers with a one-cycle ready pulse carrying read data or an error.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  CNT_INIT   = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  cnt;
  logic [2:0]  next_cnt;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  logic             cap_bad;
  logic [IDX_W-1:0] idx;
  logic             in_resp;
  logic             commit;

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // The request is latched once on accept so later bus activity cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else if (state == IDLE && bus.req) begin
      cap_we    <= bus.we;
      cap_addr  <= bus.addr;
      cap_wdata <= bus.wdata;
      cap_wstrb <= bus.wstrb;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          next_cnt   = CNT_INIT;
          next_state = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          next_state = RESP;
        end else begin
          next_cnt = cnt - 3'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    cap_bad = (cap_addr[1:0] != 2'b00) || (cap_addr >= ADDR_LIMIT);
    idx     = cap_addr[IDX_W+1:2];
    in_resp = (state == RESP);
    commit  = in_resp && cap_we && !cap_bad;
  end

  // Response outputs are decoded from state so that reset clears them immediately.
  always_comb begin
    bus.ready = in_resp;
    bus.busy  = (state != IDLE);
    bus.err   = in_resp && cap_bad;
    bus.rdata = '0;
    if (in_resp && !cap_we && !cap_bad) begin
      bus.rdata = mem[idx];
    end
  end

  // Storage is deliberately left without reset; a reset during the response
  // cycle forces state to IDLE first, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_wstrb[i]) begin
          mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
